// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU func codes, mul/div FSM state encoding and default operand width.
package mips_pkg;
    localparam int DEF_WIDTH = 32;
    localparam logic [5:0] FUNC_MULTU = 6'b010000;
    localparam logic [5:0] FUNC_DIVU  = 6'b011000;
    localparam logic [5:0] FUNC_MULT  = 6'b010001;
    localparam logic [5:0] FUNC_DIV   = 6'b011001;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_MUL  = ST_MUL,
        S_DIV  = ST_DIV,
        S_DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration sharing a single adder.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] opr_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] opr_o
);
    logic [WIDTH:0]   rem, lhs, rhs;
    logic [WIDTH+1:0] sum;
    always_comb begin
        rem = {acc_i[WIDTH-1:0], opr_i[WIDTH-1]};
        lhs = mode_i ? rem : acc_i;
        // divide subtracts via inverted operand plus carry-in; carry-out means rem >= b
        rhs = mode_i ? ~{1'b0, b_i} : (opr_i[0] ? {1'b0, b_i} : '0);
        sum = {1'b0, lhs} + {1'b0, rhs} + {{(WIDTH+1){1'b0}}, mode_i};
        acc_o = mode_i ? (sum[WIDTH+1] ? sum[WIDTH:0] : rem) : {1'b0, sum[WIDTH:1]};
        opr_o = mode_i ? {opr_i[WIDTH-2:0], sum[WIDTH+1]} : {sum[0], opr_i[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide responder returning results in HI/LO.
// Signed MULT/DIV support is enabled by defining MULDIV_SIGNED_EN.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start_in,
    input  logic [5:0]       Func_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             Busy_out,
    output logic             Done_out,
    output logic             Err_out,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d, acc_n;
    logic [WIDTH-1:0]   opr_q, opr_d, opr_n, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, err_q, err_d;
    logic               is_sgn, valid, is_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, rem_f, quo_f;
    logic [2*WIDTH-1:0] prod, prod_f;

`ifdef MULDIV_SIGNED_EN
    assign is_sgn = (Func_in == FUNC_MULT) || (Func_in == FUNC_DIV);
`else
    assign is_sgn = 1'b0;
`endif
    assign valid  = (Func_in == FUNC_MULTU) || (Func_in == FUNC_DIVU) || is_sgn;
    assign is_div = (Func_in == FUNC_DIVU) || (Func_in == FUNC_DIV);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_i(state_q == S_DIV),
        .acc_i (acc_q),
        .opr_i (opr_q),
        .b_i   (b_q),
        .acc_o (acc_n),
        .opr_o (opr_n)
    );

    always_comb begin
        a_neg  = is_sgn & A_in[WIDTH-1];
        b_neg  = is_sgn & B_in[WIDTH-1];
        a_mag  = a_neg ? -A_in : A_in;
        b_mag  = b_neg ? -B_in : B_in;
        prod   = {acc_n[WIDTH-1:0], opr_n};
        prod_f = neg_q ? -prod : prod;
        // remainder follows dividend sign, quotient follows sign difference
        rem_f  = rneg_q ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
        quo_f  = neg_q ? -opr_n : opr_n;
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opr_d   = opr_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start_in && valid) begin
                    state_d = is_div ? S_DIV : S_MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                    opr_d   = a_mag;
                    b_d     = b_mag;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_DIV && b_q == '0) begin
                    // restoring the dividend sign recovers the original A
                    state_d = S_DONE;
                    hi_d    = rneg_q ? -opr_q : opr_q;
                    lo_d    = '1;
                    err_d   = 1'b1;
                end else begin
                    acc_d = acc_n;
                    opr_d = opr_n;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d      = S_DONE;
                        {hi_d, lo_d} = (state_q == S_DIV) ? {rem_f, quo_f} : prod_f;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opr_q   <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opr_q   <= opr_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            err_q   <= err_d;
        end
    end

    assign Busy_out = (state_q != S_IDLE);
    assign Done_out = (state_q == S_DONE);
    assign Err_out  = err_q;
    assign Hi_out   = hi_q;
    assign Lo_out   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven directed checks of muldiv_unit plus reset/handshake sequences.
module tb_muldiv_unit;
    logic        clk = 1'b0, reset_n = 1'b1, Start_in = 1'b0;
    logic [5:0]  Func_in = '0;
    logic [31:0] A_in = '0, B_in = '0;
    logic        Busy_out, Done_out, Err_out;
    logic [31:0] Hi_out, Lo_out;
    int          total = 0, bad = 0;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, hi, lo;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vq[$];

    muldiv_unit dut (
        .clk(clk), .reset_n(reset_n), .Start_in(Start_in), .Func_in(Func_in),
        .A_in(A_in), .B_in(B_in), .Busy_out(Busy_out), .Done_out(Done_out),
        .Err_out(Err_out), .Hi_out(Hi_out), .Lo_out(Lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start_in = 1'b1; Func_in = f; A_in = a; B_in = b;
        @(posedge clk);
        #1;
        Start_in = 1'b0; A_in = $urandom; B_in = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!Done_out && n < 100);
    endtask

    initial begin
        int n;
        vq.push_back('{6'b010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32});
        vq.push_back('{6'b010000, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 32});
        vq.push_back('{6'b010000, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 32});
        vq.push_back('{6'b010000, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 32});
        vq.push_back('{6'b010000, 32'h80000000, 32'd2, 32'd1, 32'd0, 1'b0, 32});
        vq.push_back('{6'b011000, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32});
        vq.push_back('{6'b011000, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1});
        vq.push_back('{6'b011000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 32});
        vq.push_back('{6'b011000, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 32});
        vq.push_back('{6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 32});
`ifdef MULDIV_SIGNED_EN
        vq.push_back('{6'b010001, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 32});
        vq.push_back('{6'b010001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 32});
        vq.push_back('{6'b011001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32});
        vq.push_back('{6'b011001, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 32});
        vq.push_back('{6'b011001, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1});
`endif
        #1 reset_n = 1'b0;
        #20;
        chk("rst_busy", {31'd0, Busy_out}, 32'd0);
        chk("rst_done", {31'd0, Done_out}, 32'd0);
        chk("rst_err", {31'd0, Err_out}, 32'd0);
        chk("rst_hi", Hi_out, 32'd0);
        chk("rst_lo", Lo_out, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            issue(vq[i].f, vq[i].a, vq[i].b);
            chk($sformatf("v%0d_busy", i), {31'd0, Busy_out}, 32'd1);
            wait_done(n);
            chk($sformatf("v%0d_lat", i), n, vq[i].lat);
            chk($sformatf("v%0d_hi", i), Hi_out, vq[i].hi);
            chk($sformatf("v%0d_lo", i), Lo_out, vq[i].lo);
            chk($sformatf("v%0d_err", i), {31'd0, Err_out}, {31'd0, vq[i].err});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_idle", i), {29'd0, Busy_out, Done_out, Err_out}, 32'd0);
        end

        // Start held high with new operands through busy and DONE: only one completion
        issue(6'b010000, 32'd7, 32'd6);
        Start_in = 1'b1; Func_in = 6'b011000; A_in = 32'd100; B_in = 32'd7;
        wait_done(n);
        chk("hold_lat", n, 32);
        chk("hold_hi", Hi_out, 32'd0);
        chk("hold_lo", Lo_out, 32'd42);
        @(posedge clk);
        #1;
        chk("hold_done_start_ignored", {30'd0, Busy_out, Done_out}, 32'd0);
        Start_in = 1'b0;

        @(negedge clk);
        Start_in = 1'b1; Func_in = 6'b100000; A_in = 32'd9; B_in = 32'd9;
        @(posedge clk);
        #1;
        chk("badfunc_busy", {31'd0, Busy_out}, 32'd0);
        chk("badfunc_hi", Hi_out, 32'd0);
        chk("badfunc_lo", Lo_out, 32'd42);
        Start_in = 1'b0;
`ifndef MULDIV_SIGNED_EN
        @(negedge clk);
        Start_in = 1'b1; Func_in = 6'b010001; A_in = 32'hFFFFFFFD; B_in = 32'd5;
        @(posedge clk);
        #1;
        chk("mult_off_busy", {31'd0, Busy_out}, 32'd0);
        chk("mult_off_lo", Lo_out, 32'd42);
        Start_in = 1'b0;
`endif

        issue(6'b010000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, Busy_out}, 32'd0);
        chk("abort_hi", Hi_out, 32'd0);
        chk("abort_lo", Lo_out, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        issue(6'b010000, 32'h00010000, 32'h00030000);
        wait_done(n);
        chk("post_rst_lat", n, 32);
        chk("post_rst_hi", Hi_out, 32'd3);
        chk("post_rst_lo", Lo_out, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, Busy_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle responder for the multiply/divide function codes that the single-cycle ALU decodes but does not execute: unsigned multiply 010000 and unsigned divide 011000.
- Decode issues a request with Start_in. The unit computes iteratively and returns results in HI/LO registers, which the datapath reads for MFHI/MFLO.
- Handshake: Busy_out, plus a one-cycle Done_out pulse.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- Start_in  input  1  request strobe, sampled only in IDLE
- Func_in  input  6  operation code, ALU encoding
- A_in  input  WIDTH  multiplicand / dividend
- B_in  input  WIDTH  multiplier / divisor
- Busy_out  output  1  operation in progress
- Done_out  output  1  one-cycle completion pulse
- Err_out  output  1  divide-by-zero flag, valid with Done_out
- Hi_out  output  WIDTH  HI register: product upper half / remainder
- Lo_out  output  WIDTH  LO register: product lower half / quotient

Behaviour:
- Reset (asynchronous, active-low): state IDLE, counter 0, Hi_out=0, Lo_out=0, Busy_out=0, Done_out=0, Err_out=0. Asserting reset mid-operation aborts the operation and discards any partial result.
- States: IDLE, MUL, DIV, DONE.
  - Busy_out = (state != IDLE).
  - Done_out = (state == DONE).
  - All outputs are registered or Moore.
- Accept (edge E):
  - Start_in=1 in IDLE with a valid Func_in latches A_in, B_in and the opcode.
  - Next state is MUL (010000) or DIV (011000); counter cleared.
  - After E, A_in and B_in are don't-care.
- Ignored requests:
  - Start_in with any other Func_in: no state change, no flag.
  - Start_in while Busy_out=1: ignored; no queueing.
- MUL: shift-add, one bit per cycle.
  - Accumulator is WIDTH+1 bits; multiplier is held in the low half.
  - Each cycle: if the low bit is 1, add B to the accumulator; then shift the combined {acc, mplier} right by 1.
  - Runs WIDTH cycles (counter 0..WIDTH-1), then DONE.
- DIV: restoring division, one bit per cycle.
  - Each cycle: R = {R, Q[msb]}; if R >= B, subtract B and shift 1 into Q, else shift 0 into Q.
  - Runs WIDTH cycles, then DONE.
- DONE (one cycle):
  - Hi/Lo are written on the edge that enters DONE: product {Hi,Lo}, or remainder in Hi and quotient in Lo.
  - Next state is always IDLE. Start_in is not accepted in DONE.
- Latency: DONE is entered at edge E+WIDTH, so Done_out is high from E+32 to E+33. Busy_out is high from E to E+33.
- Divide by zero (B=0 at accept):
  - Skip iteration and go IDLE→DONE at edge E+1.
  - Hi=A, Lo=all ones, Err_out=1 for that DONE cycle only.
- Hi/Lo hold their value until the next completed operation. Ignored requests never alter them.
- Widths:
  - Multiply produces the full 2*WIDTH-bit product; it cannot overflow.
  - Divide returns quotient and remainder with remainder < divisor.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- When defined:
  - Func 010001 (signed multiply) and 011001 (signed divide) are accepted.
  - Operands are converted to magnitudes at accept; the sign-fix step is registered during DONE entry.
  - The product is negated when the operand signs differ.
  - The quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - Latency is unchanged.
  - Special cases: signed divide by zero behaves as unsigned (Hi=A, Lo=all ones, Err). 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- When undefined: 010001 and 011001 are invalid and ignored, as in Behaviour.

Decomposition:
- Shared package `mips_pkg` holds:
  - Func code constants: FUNC_MULTU, FUNC_DIVU, FUNC_MULT, FUNC_DIV.
  - State encoding localparams.
  - WIDTH default.
- One natural sub-module: `muldiv_step`, a combinational single-iteration datapath.
  - Inputs: mode, acc, operand register, B.
  - Outputs: next acc and next operand register.
  - Lets MUL and DIV share a single WIDTH+1 adder/subtractor.

Test Plan:
- Reset: hold reset_n=0 mid-MUL at cycle 10 → Busy=0 and Hi/Lo=0 immediately; a new request after release runs a full 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → Done_out at accept+32; Hi=0xFFFFFFFE, Lo=0x00000001; Err=0.
- DIVU 100 / 7 → Lo=14, Hi=2; DIVU 5 / 0 → Done at accept+1, Err=1, Hi=5, Lo=0xFFFFFFFF.
- Start_in held high with new operands during Busy, and Start_in with Func 100000 in IDLE → both ignored; Hi/Lo unchanged; exactly one Done pulse per accepted request.
- Back-to-back: Start_in high in the cycle after Done (IDLE) → accepted; Start_in during the DONE cycle → not accepted.
- MULDIV_SIGNED_EN: MULT -3 × 5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; DIV -7 / 2 → Lo=-3, Hi=-1. Without the macro, Func 010001 is ignored.
